uart_cmd_decoder: RTL and testbench

- Sits directly downstream of the UART RX FIFO and upstream of the UART TX FIFO.
- Pops received ASCII bytes from the RX FIFO and decodes single-character control commands and a set-time command ("T" + 6 digits + CR) into one-cycle control pulses for the watch/stopwatch logic.
- Pushes a one-byte acknowledge ('K' or '?') into the TX FIFO.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/bcd_pair_to_bin.sv | 12 +
 rtl/uart_cmd_decoder.sv | 139 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: ASCII constants, decoder state enum and digit-count width for uart_cmd_decoder
package uart_cmd_pkg;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_R_U = 8'h52;
  localparam logic [7:0] CH_R_L = 8'h72;
  localparam logic [7:0] CH_C_U = 8'h43;
  localparam logic [7:0] CH_C_L = 8'h63;
  localparam logic [7:0] CH_M_U = 8'h4D;
  localparam logic [7:0] CH_M_L = 8'h6D;
  localparam logic [7:0] CH_T_U = 8'h54;
  localparam logic [7:0] CH_T_L = 8'h74;
  localparam int CNT_W = 3;
  typedef enum logic [2:0] {IDLE, DIGIT, WAIT_CR, CHECK, ACK} state_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction
endpackage

// File: rtl/bcd_pair_to_bin.sv
// bcd_pair_to_bin: two decimal digits to binary, with a range flag
// hi, lo: decimal digits (0-9); limit: exclusive upper bound; value: hi*10+lo; in_range: value < limit
module bcd_pair_to_bin (
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       in_range
);
  assign value = {3'b000, hi} * 7'd10 + {3'b000, lo};
  assign in_range = value < limit;
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: decodes RX FIFO ASCII commands into control pulses and pushes an ack byte to the TX FIFO
// rx_empty/rx_data/rx_pop: show-ahead RX FIFO side; tx_full/tx_push/tx_data: TX FIFO side
// cmd_run/cmd_clear/cmd_mode/parse_err: one-cycle pulses; set_valid strobes set_hour/set_min/set_sec
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter bit         ACK_EN  = 1'b1,
  parameter logic [7:0] ACK_OK  = 8'h4B,
  parameter logic [7:0] ACK_ERR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       parse_err
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0] dig [6];
  logic run_n, clear_n, mode_n, err_n, setv_n, ack_ld, ack_ok, dig_we, cnt_clr;
  logic [6:0] hour, min, sec;
  logic h_ok, m_ok, s_ok;
  bcd_pair_to_bin u_hour (.hi(dig[0]), .lo(dig[1]), .limit(7'd24), .value(hour), .in_range(h_ok));
  bcd_pair_to_bin u_min  (.hi(dig[2]), .lo(dig[3]), .limit(7'd60), .value(min),  .in_range(m_ok));
  bcd_pair_to_bin u_sec  (.hi(dig[4]), .lo(dig[5]), .limit(7'd60), .value(sec),  .in_range(s_ok));
  always_comb begin
    rx_pop = ~rx_empty && (state == IDLE || state == DIGIT || state == WAIT_CR);
    tx_push = ACK_EN && state == ACK && ~tx_full;
    state_n = state;
    run_n = 1'b0;
    clear_n = 1'b0;
    mode_n = 1'b0;
    err_n = 1'b0;
    setv_n = 1'b0;
    ack_ld = 1'b0;
    ack_ok = 1'b0;
    dig_we = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      IDLE: if (rx_pop) begin
        if (rx_data == CH_R_U || rx_data == CH_R_L) begin
          run_n = 1'b1;
          ack_ld = 1'b1;
          ack_ok = 1'b1;
        end else if (rx_data == CH_C_U || rx_data == CH_C_L) begin
          clear_n = 1'b1;
          ack_ld = 1'b1;
          ack_ok = 1'b1;
        end else if (rx_data == CH_M_U || rx_data == CH_M_L) begin
          mode_n = 1'b1;
          ack_ld = 1'b1;
          ack_ok = 1'b1;
        end else if (rx_data == CH_T_U || rx_data == CH_T_L) begin
          state_n = DIGIT;
          cnt_clr = 1'b1;
        end else if (rx_data != CH_CR && rx_data != CH_LF) begin
          err_n = 1'b1;
          ack_ld = 1'b1;
        end
      end
      DIGIT: if (rx_pop) begin
        if (is_digit(rx_data)) begin
          dig_we = 1'b1;
          state_n = cnt == CNT_W'(5) ? WAIT_CR : DIGIT;
        end else if (rx_data == CH_ESC) begin
          state_n = IDLE;
        end else begin
          err_n = 1'b1;
          ack_ld = 1'b1;
        end
      end
      WAIT_CR: if (rx_pop) begin
        if (rx_data == CH_CR) begin
          state_n = CHECK;
        end else if (rx_data == CH_ESC) begin
          state_n = IDLE;
        end else begin
          err_n = 1'b1;
          ack_ld = 1'b1;
        end
      end
      CHECK: begin
        setv_n = h_ok && m_ok && s_ok;
        err_n = ~setv_n;
        ack_ld = 1'b1;
        ack_ok = setv_n;
      end
      ACK: state_n = tx_full ? ACK : IDLE;
      default: state_n = IDLE;
    endcase
    // every completed command or error funnels through here; ACK is bypassed when acks are disabled
    if (ack_ld) state_n = ACK_EN ? ACK : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      for (int i = 0; i < 6; i++) dig[i] <= '0;
      cmd_run <= 1'b0;
      cmd_clear <= 1'b0;
      cmd_mode <= 1'b0;
      set_valid <= 1'b0;
      parse_err <= 1'b0;
      tx_data <= '0;
      set_hour <= '0;
      set_min <= '0;
      set_sec <= '0;
    end else begin
      state <= state_n;
      cmd_run <= run_n;
      cmd_clear <= clear_n;
      cmd_mode <= mode_n;
      set_valid <= setv_n;
      parse_err <= err_n;
      if (cnt_clr) cnt <= '0;
      else if (dig_we) begin
        dig[cnt] <= rx_data[3:0];
        cnt <= cnt + 1'b1;
      end
      if (ack_ld) tx_data <= ack_ok ? ACK_OK : ACK_ERR;
      if (setv_n) begin
        set_hour <= 5'(hour);
        set_min <= 6'(min);
        set_sec <= 6'(sec);
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_empty = 1'b1, tx_full = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_pop, tx_push, cmd_run, cmd_clear, cmd_mode, set_valid, parse_err;
  logic [7:0] tx_data;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  int checks = 0, failures = 0;
  int n_run, n_clear, n_mode, n_setv, n_err, n_push, n_pop;
  logic [7:0] last_tx;
  logic [7:0] q [$];
  uart_cmd_decoder dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data), .cmd_run(cmd_run),
    .cmd_clear(cmd_clear), .cmd_mode(cmd_mode), .set_valid(set_valid), .set_hour(set_hour),
    .set_min(set_min), .set_sec(set_sec), .parse_err(parse_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    n_run += int'(cmd_run);
    n_clear += int'(cmd_clear);
    n_mode += int'(cmd_mode);
    n_setv += int'(set_valid);
    n_err += int'(parse_err);
    n_pop += int'(rx_pop);
    if (tx_push) begin
      n_push++;
      last_tx = tx_data;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic refresh();
    rx_empty = q.size() == 0;
    rx_data = rx_empty ? 8'h00 : q[0];
  endtask
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    refresh();
  endtask
  task automatic cyc();
    logic p;
    #1;
    p = rx_pop;
    @(posedge clk);
    #1;
    if (p) void'(q.pop_front());
    refresh();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic clr();
    n_run = 0; n_clear = 0; n_mode = 0; n_setv = 0; n_err = 0; n_push = 0; n_pop = 0;
    last_tx = 8'h00;
  endtask
  initial begin
    clr();
    run(2);
    chk("reset_rx_pop", rx_pop, 0);
    chk("reset_tx_push", tx_push, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_pulses", {cmd_run, cmd_clear, cmd_mode, set_valid, parse_err}, 0);
    chk("reset_set", {set_hour, set_min, set_sec}, 0);
    rst = 1'b0;
    run(1);
    push_str("R");
    #1;
    chk("r_pop_high", rx_pop, 1);
    chk("r_run_not_yet", cmd_run, 0);
    cyc();
    chk("r_run_pulse", cmd_run, 1);
    chk("r_push", tx_push, 1);
    chk("r_tx_data", tx_data, 8'h4B);
    chk("r_no_pop_in_ack", rx_pop, 0);
    chk("r_others", {cmd_clear, cmd_mode, set_valid, parse_err}, 0);
    cyc();
    chk("r_run_done", cmd_run, 0);
    chk("r_push_done", tx_push, 0);
    clr();
    push_str("T123456\015");
    run(12);
    chk("set_valid_cnt", n_setv, 1);
    chk("set_hour", set_hour, 12);
    chk("set_min", set_min, 34);
    chk("set_sec", set_sec, 56);
    chk("set_pops", n_pop, 8);
    chk("set_push_cnt", n_push, 1);
    chk("set_ack", last_tx, 8'h4B);
    chk("set_err_cnt", n_err, 0);
    clr();
    push_str("T245900\015");
    run(12);
    chk("bad_hour_err", n_err, 1);
    chk("bad_hour_setv", n_setv, 0);
    chk("bad_hour_held", {set_hour, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
    chk("bad_hour_ack", last_tx, 8'h3F);
    chk("bad_hour_push_cnt", n_push, 1);
    clr();
    push_str("T12a");
    run(8);
    chk("bad_digit_err", n_err, 1);
    chk("bad_digit_pops", n_pop, 4);
    chk("bad_digit_ack", last_tx, 8'h3F);
    clr();
    push_str("C");
    run(4);
    chk("after_err_clear", n_clear, 1);
    chk("after_err_ack", last_tx, 8'h4B);
    chk("after_err_err", n_err, 0);
    clr();
    push_str("T12\033M");
    run(10);
    chk("esc_push_cnt", n_push, 1);
    chk("esc_mode", n_mode, 1);
    chk("esc_err", n_err, 0);
    chk("esc_ack", last_tx, 8'h4B);
    chk("esc_pops", n_pop, 5);
    clr();
    tx_full = 1'b1;
    push_str("RC");
    run(4);
    chk("stall_run", n_run, 1);
    chk("stall_no_push", n_push, 0);
    chk("stall_c_pending", q.size(), 1);
    chk("stall_no_pop", rx_pop, 0);
    tx_full = 1'b0;
    run(6);
    chk("release_push_cnt", n_push, 2);
    chk("release_clear", n_clear, 1);
    chk("release_ack", last_tx, 8'h4B);
    chk("release_q_empty", q.size(), 0);
    clr();
    push_str("T12");
    run(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_set", {set_hour, set_min, set_sec}, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_pulses", {tx_push, cmd_run, cmd_clear, cmd_mode, set_valid, parse_err}, 0);
    run(2);
    rst = 1'b0;
    run(1);
    clr();
    push_str("5");
    run(4);
    chk("post_rst_idle_err", n_err, 1);
    chk("post_rst_idle_ack", last_tx, 8'h3F);
    clr();
    push_str("m");
    run(4);
    chk("post_rst_mode", n_mode, 1);
    chk("post_rst_mode_ack", last_tx, 8'h4B);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
